// File: rtl/matrix_block_feeder.sv
// matrix_block_feeder: gathers 8 streamed fp32 words into held 2x2 A/B operands.
// Define FEEDER_DOUBLE_BUFFER_EN to add a second fill bank that overlaps issue.
module matrix_block_feeder #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   input_Clk,
  input  logic                   input_Reset,
  input  logic [DATA_WIDTH-1:0]  input_Data,
  input  logic                   input_Valid,
  output logic                   output_Ready,
  output logic [DATA_WIDTH-1:0]  output_A11,
  output logic [DATA_WIDTH-1:0]  output_A12,
  output logic [DATA_WIDTH-1:0]  output_A21,
  output logic [DATA_WIDTH-1:0]  output_A22,
  output logic [DATA_WIDTH-1:0]  output_B11,
  output logic [DATA_WIDTH-1:0]  output_B12,
  output logic [DATA_WIDTH-1:0]  output_B21,
  output logic [DATA_WIDTH-1:0]  output_B22,
  output logic                   output_Stable,
  input  logic                   input_AB_Ack,
  output logic [COUNT_WIDTH-1:0] output_Blocks_Issued
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [DATA_WIDTH-1:0]  ops   [8];
  logic [DATA_WIDTH-1:0]  set_n [8];
  logic [2:0]             idx;
  logic [COUNT_WIDTH-1:0] blocks;
  logic                   ready;
  logic                   take;
  logic                   last;
  logic                   go;
  logic                   load;
  logic                   ack_take;

  assign take = input_Valid && ready;
  assign last = take && (idx == 3'd7);

`ifdef FEEDER_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] bank0 [8];
  logic [DATA_WIDTH-1:0] bank1 [8];
  logic [1:0]            full;
  logic                  wsel;
  logic                  psel;
  logic                  cand;

  // The next bank to present is always the one not currently presented,
  // which keeps issue order equal to fill order.
  assign cand  = ~psel;
  assign ready = !input_Reset && !full[wsel];
  assign go    = full[cand] || (last && (wsel == cand));

  // Candidate operand set, with a word landing this edge bypassed in
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      set_n[i] = cand ? bank1[i] : bank0[i];
    end
    if (last && (wsel == cand)) begin
      set_n[7] = input_Data;
    end
  end

  // Bank write port
  always_ff @(posedge input_Clk) begin
    if (take) begin
      if (wsel) begin
        bank1[idx] <= input_Data;
      end else begin
        bank0[idx] <= input_Data;
      end
    end
  end

  // Bank occupancy: set on completion, freed once the multiplier acks
  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      full <= 2'b00;
      wsel <= 1'b0;
      psel <= 1'b1;
    end else begin
      if (ack_take) begin
        full[psel] <= 1'b0;
      end
      if (last) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (load) begin
        psel <= cand;
      end
    end
  end
`else
  logic [DATA_WIDTH-1:0] stage [7];

  assign ready = !input_Reset && (state == FILL);
  assign go    = last;

  // Words 0..6 come from staging, word 7 straight from the input
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      set_n[i] = stage[i];
    end
    set_n[7] = input_Data;
  end

  // Staging write port for the first seven words of a set
  always_ff @(posedge input_Clk) begin
    if (take && (idx != 3'd7)) begin
      stage[idx] <= input_Data;
    end
  end
`endif

  // State register
  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake strobes
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ack_take = 1'b0;
    unique case (state)
      FILL: begin
        if (go) begin
          state_n = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (input_AB_Ack) begin
          state_n  = RELEASE;
          ack_take = 1'b1;
        end
      end
      RELEASE: begin
        if (!input_AB_Ack) begin
          if (go) begin
            state_n = ISSUE;
            load    = 1'b1;
          end else begin
            state_n = FILL;
          end
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

  // Word index, held operand set and issued-block count
  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      idx    <= 3'd0;
      blocks <= '0;
      for (int i = 0; i < 8; i++) begin
        ops[i] <= '0;
      end
    end else begin
      if (take) begin
        idx <= idx + 3'd1;
      end
      if (ack_take) begin
        blocks <= blocks + 1'b1;
      end
      if (load) begin
        for (int i = 0; i < 8; i++) begin
          ops[i] <= set_n[i];
        end
      end
    end
  end

  assign output_Ready         = ready;
  assign output_Stable        = (state == ISSUE);
  assign output_Blocks_Issued = blocks;
  assign output_A11           = ops[0];
  assign output_A12           = ops[1];
  assign output_A21           = ops[2];
  assign output_A22           = ops[3];
  assign output_B11           = ops[4];
  assign output_B12           = ops[5];
  assign output_B21           = ops[6];
  assign output_B22           = ops[7];

endmodule

// File: tb/tb_matrix_block_feeder.sv
// tb_matrix_block_feeder: directed stimulus, scoreboard of expected operand
// sets checked by a monitor each time the feeder raises output_Stable.
`timescale 1ns/1ps
module tb_matrix_block_feeder;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam logic [8*W-1:0] SET1 = {
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  localparam logic [8*W-1:0] SET2 = {
    32'h12345678, 32'h23456789, 32'h3456789A, 32'h456789AB,
    32'h56789ABC, 32'h6789ABCD, 32'h789ABCDE, 32'h89ABCDEF};
  localparam logic [8*W-1:0] SET3 = {
    32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000,
    32'hC0A00000, 32'hC0C00000, 32'hC0E00000, 32'hC1000000};
  localparam logic [8*W-1:0] SET4 = {
    32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000,
    32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};
`ifdef FEEDER_DOUBLE_BUFFER_EN
  localparam logic REL_READY = 1'b1;
`else
  localparam logic REL_READY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [W-1:0]  din = '0;
  logic          mack = 1'b0;
  logic          force_ack = 1'b0;
  logic          ack;
  logic          rdy;
  logic          stable;
  logic [W-1:0]  a11, a12, a21, a22, b11, b12, b21, b22;
  logic [CW-1:0] count;
  logic [8*W-1:0] ops_flat;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int ack_hold = 0;
  int wc = 0;
  int hc = 0;
  logic [8*W-1:0] expq [$];

  string names [8] = '{"A11", "A12", "A21", "A22",
                       "B11", "B12", "B21", "B22"};

  assign ack      = mack | force_ack;
  assign ops_flat = {a11, a12, a21, a22, b11, b12, b21, b22};

  always #5 clk = ~clk;

  matrix_block_feeder #(.DATA_WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .input_Clk            (clk),
    .input_Reset          (rst),
    .input_Data           (din),
    .input_Valid          (vld),
    .output_Ready         (rdy),
    .output_A11           (a11),
    .output_A12           (a12),
    .output_A21           (a21),
    .output_A22           (a22),
    .output_B11           (b11),
    .output_B12           (b12),
    .output_B21           (b21),
    .output_B22           (b22),
    .output_Stable        (stable),
    .input_AB_Ack         (ack),
    .output_Blocks_Issued (count)
  );

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Multiplier model: ack after ack_delay cycles of Stable, hold after fall
  always @(negedge clk) begin
    if (rst) begin
      mack = 1'b0;
      wc   = 0;
      hc   = 0;
    end else if (!mack && stable) begin
      if (wc >= ack_delay) begin
        mack = 1'b1;
        wc   = 0;
        hc   = 0;
      end else begin
        wc++;
      end
    end else if (mack && !stable) begin
      if (hc >= ack_hold) mack = 1'b0;
      else hc++;
    end else if (!stable) begin
      wc = 0;
    end
  end

  // Monitor: pop and compare on each Stable rise, check hold on fall
  logic           in_issue = 1'b0;
  logic           moved = 1'b0;
  int             len = 0;
  int             exp_blocks = 0;
  logic [8*W-1:0] cap;
  logic [8*W-1:0] expv;

  always @(negedge clk) begin
    if (rst) begin
      in_issue   = 1'b0;
      exp_blocks = 0;
    end else if (stable && !in_issue) begin
      in_issue = 1'b1;
      len      = 1;
      moved    = 1'b0;
      cap      = ops_flat;
      if (expq.size() == 0) begin
        timeout("unexpected_set");
      end else begin
        expv = expq.pop_front();
        for (int i = 0; i < 8; i++) begin
          chk(names[i], ops_flat[(7-i)*W +: W], expv[(7-i)*W +: W]);
        end
      end
    end else if (stable && in_issue) begin
      len++;
      if (ops_flat !== cap) moved = 1'b1;
    end else if (!stable && in_issue) begin
      in_issue = 1'b0;
      exp_blocks++;
      chk("hold_ops", {31'd0, moved}, 32'd0);
      chk("stable_len", len, ack_delay + 1);
      chk("blocks", {16'd0, count}, exp_blocks);
    end
  end

  task automatic send(input logic [8*W-1:0] set, input int n,
                      input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = 0;
      while (!rdy && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (!rdy) timeout("ready_wait");
      vld = 1'b1;
      din = set[(7-i)*W +: W];
      @(posedge clk);
      #1;
      vld = 1'b0;
      din = 32'hDEADBEEF;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    int ok;
    k  = 0;
    ok = 0;
    while (ok < 2 && k < 400) begin
      @(negedge clk);
      k++;
      if (expq.size() == 0 && !stable && !mack && rdy) ok++;
      else ok = 0;
    end
    if (ok < 2) timeout("idle_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_stable", {31'd0, stable}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_A11", a11, 32'd0);
    chk("rst_B22", b22, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy}, 32'd1);

    // Long ack wait, ack held after release
    ack_delay = 20;
    ack_hold  = 5;
    expq.push_back(SET1);
    send(SET1, 8, 0);
    k = 0;
    while (stable && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (stable) timeout("release_wait");
    for (int i = 0; i < 5; i++) begin
      chk("rel_stable", {31'd0, stable}, 32'd0);
      chk("rel_ready", {31'd0, rdy}, {31'd0, REL_READY});
      @(negedge clk);
    end
    wait_idle();

    // Ack while filling is ignored
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("fill_ack_stable", {31'd0, stable}, 32'd0);
    chk("fill_ack_count", {16'd0, count}, 32'd1);
    force_ack = 1'b0;
    @(negedge clk);

    // Valid toggling every other cycle
    ack_delay = 2;
    ack_hold  = 0;
    expq.push_back(SET1);
    send(SET1, 8, 1);
    wait_idle();
    chk("count_two", {16'd0, count}, 32'd2);

    // Reset after a partial set discards it
    send(SET2, 5, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_count", {16'd0, count}, 32'd0);
    chk("midrst_A11", a11, 32'd0);
    chk("midrst_ready", {31'd0, rdy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sixteen words back to back, slow multiplier
    ack_delay = 10;
    ack_hold  = 0;
    expq.push_back(SET3);
    expq.push_back(SET4);
    send(SET3, 8, 0);
    send(SET4, 8, 0);
    wait_idle();
    chk("count_after_16", {16'd0, count}, 32'd2);
    chk("final_stable", {31'd0, stable}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
